// File: rtl/bcd2bin_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
//   state_t : FSM state encoding (S_IDLE, S_SHIFT, S_DONE)
//   clog2   : constant ceil(log2(v)), used for counter width and the
//             result-width legality check
package bcd2bin_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    int p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd2bin_seq_bcd_digit_adjust.sv
// Per-digit combinational helper for reverse double-dabble.
//   adj_in  : post-shift BCD digit
//   adj_out : adj_in - 3 when adj_in >= 8, else adj_in (4-bit wrap)
//   chk_in  : raw input digit to validate
//   gt9     : high when chk_in is not a legal BCD digit
module bcd_digit_adjust (
  input  logic [3:0] adj_in,
  output logic [3:0] adj_out,
  input  logic [3:0] chk_in,
  output logic       gt9
);

  assign adj_out = (adj_in >= 4'd8) ? (adj_in - 4'd3) : adj_in;
  assign gt9     = (chk_in > 4'd9);

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one
// shift/correct step per clock with a Start/Busy/Done handshake.
//   Clock  : system clock
//   Resetn : synchronous active-low reset
//   Start  : request, sampled only in S_IDLE
//   D      : packed BCD input, D[3:0] least significant digit
//   Q      : registered binary result, held until next completion
//   Busy   : conversion in progress
//   Done   : one-cycle pulse when Q/Err are valid
//   Err    : latest accepted D held a digit > 9
//
// state   | meaning
// S_IDLE  | waiting for Start; D validated and loaded on acceptance
// S_SHIFT | one shift/adjust step per edge, cnt steps remaining
// S_DONE  | Done pulse for one cycle, Start ignored
module bcd2bin_seq
  import bcd2bin_seq_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Start,
  input  logic [4*DIGITS-1:0]   D,
  output logic [BIN_W-1:0]      Q,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = clog2(BIN_W + 1);

  if (BIN_W < clog2(10 ** DIGITS)) begin : g_bad_width
    $error("bcd2bin_seq: BIN_W too small for DIGITS");
  end

  state_t           state;
  logic [BCD_W-1:0] bcd_q;
  logic [BIN_W-1:0] bin_q;
  logic [CNT_W-1:0] cnt;

  logic [BCD_W-1:0] shifted_bcd;
  logic [BCD_W-1:0] adj_bcd;
  logic [BIN_W-1:0] shifted_bin;
  logic [DIGITS-1:0] gt9;

  // Working register {bcd, bin} shifted right by one; bin[0] falls off.
  assign shifted_bcd = {1'b0, bcd_q[BCD_W-1:1]};
  assign shifted_bin = {bcd_q[0], bin_q[BIN_W-1:1]};

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_adjust u_adj (
      .adj_in  (shifted_bcd[4*i +: 4]),
      .adj_out (adj_bcd[4*i +: 4]),
      .chk_in  (D[4*i +: 4]),
      .gt9     (gt9[i])
    );
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= S_IDLE;
      bcd_q <= '0;
      bin_q <= '0;
      cnt   <= '0;
      Q     <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            if (|gt9) begin
              // Invalid digit: skip conversion, report in one edge.
              Err   <= 1'b1;
              Q     <= '0;
              Done  <= 1'b1;
              state <= S_DONE;
            end else begin
              bcd_q <= D;
              bin_q <= '0;
              cnt   <= CNT_W'(BIN_W);
              Busy  <= 1'b1;
              Err   <= 1'b0;
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          bcd_q <= adj_bcd;
          bin_q <= shifted_bin;
          cnt   <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            Q     <= shifted_bin;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          Done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
module tb_bcd2bin_seq;

  logic       clk;
  logic       rstn;
  logic       start;
  logic [7:0] d;
  logic [6:0] q;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  bcd2bin_seq #(.DIGITS(2), .BIN_W(7)) dut (
    .Clock  (clk),
    .Resetn (rstn),
    .Start  (start),
    .D      (d),
    .Q      (q),
    .Busy   (busy),
    .Done   (done),
    .Err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One request: Start for one cycle, then wait (bounded) for Done.
  task automatic do_req(input string tag, input logic [7:0] dv, input logic [6:0] eq,
                        input logic eerr, input int elat);
    int lat;
    int nbusy;
    @(negedge clk);
    d = dv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_err_at_accept"}, err, eerr);
    lat = 1;
    nbusy = 0;
    while (!done && lat < 30) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_busy_cycles"}, nbusy, elat - 1);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_err"}, err, eerr);
    chk({tag, "_busy_at_done"}, busy, 0);
    if (!eerr) chk({tag, "_bcd_zero"}, dut.bcd_q, 0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse_len"}, done, 0);
  endtask

  initial begin
    int lat;
    int per;
    rstn  = 1'b0;
    start = 1'b1;
    d     = 8'h99;

    // 1. Reset overrides Start.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_q", q, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
    end
    @(negedge clk);
    start = 1'b0;
    rstn  = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", busy, 0);

    // 2. Full-scale value.
    do_req("d99", 8'h99, 7'd99, 1'b0, 8);

    // 3. Sequential requests.
    do_req("d00", 8'h00, 7'd0,  1'b0, 8);
    do_req("d10", 8'h10, 7'd10, 1'b0, 8);
    do_req("d47", 8'h47, 7'd47, 1'b0, 8);
    do_req("d80", 8'h80, 7'd80, 1'b0, 8);

    // 4. Invalid digit, then recovery.
    do_req("d3a", 8'h3A, 7'd0,  1'b1, 2 - 1);
    do_req("d25", 8'h25, 7'd25, 1'b0, 8);

    // 5. Start held high, D changes mid-conversion.
    @(negedge clk);
    d = 8'h25;
    start = 1'b1;
    @(posedge clk); #1;
    chk("hold_busy_accept", busy, 1);
    repeat (3) @(posedge clk);
    #1;
    d = 8'h11;
    lat = 4;
    while (!done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hold_first_latency", lat, 8);
    chk("hold_first_q", q, 25);
    per = 0;
    @(posedge clk); #1;
    per++;
    while (!done && per < 30) begin
      @(posedge clk); #1;
      per++;
    end
    start = 1'b0;
    chk("hold_period", per, 9);
    chk("hold_second_q", q, 11);
    chk("hold_second_err", err, 0);
    @(posedge clk); #1;
    chk("hold_done_drop", done, 0);
    @(posedge clk); #1;
    chk("hold_idle_busy", busy, 0);

    // 6. Reset mid-conversion.
    @(negedge clk);
    d = 8'h55;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_busy3", busy, 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("abort_q", q, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err, 0);
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) lat++;
    end
    chk("abort_no_activity", lat, 0);
    do_req("d64", 8'h64, 7'd64, 1'b0, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
